// File: rtl/alu_exec_stage.sv
// Execute/writeback stage wrapped around an external 16-bit ALU: one instruction
// in flight, operands read from an 8x16 register file, result written back on handshake.
module alu_exec_stage #(
    parameter int NREGS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_bneg,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    input  logic        alu_cout,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [2:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_c,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [15:0]            alu_a_q, alu_a_d;
    logic [15:0]            alu_b_q, alu_b_d;
    logic                   alu_bneg_q, alu_bneg_d;
    logic [2:0]             alu_op_q, alu_op_d;
    logic [2:0]             rd_q, rd_d;
    logic [15:0]            wb_data_q, wb_data_d;
    logic [2:0]             pend_q, pend_d;   // {z, v, c} captured from the ALU
    logic [2:0]             flags_q, flags_d;
    logic [NREGS-1:0][15:0] rf_q, rf_d;

    logic [2:0]  i_rd, i_rs, i_rt;
    logic        i_use_imm;
    logic [15:0] i_imm;

    assign i_rd      = in_instr[10:8];
    assign i_rs      = in_instr[7:5];
    assign i_rt      = in_instr[4:2];
    assign i_use_imm = in_instr[11];
    assign i_imm     = {{11{in_instr[4]}}, in_instr[4:0]};

    // r0 is forced to zero on every read port, independent of storage.
    function automatic logic [15:0] rf_read(input logic [NREGS-1:0][15:0] rf,
                                            input logic [2:0] addr);
        return (addr == 3'd0) ? 16'h0000 : rf[addr];
    endfunction

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_bneg_d = alu_bneg_q;
        alu_op_d   = alu_op_q;
        rd_d       = rd_q;
        wb_data_d  = wb_data_q;
        pend_d     = pend_q;
        flags_d    = flags_q;
        rf_d       = rf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d    = S_EXEC;
                    alu_a_d    = rf_read(rf_q, i_rs);
                    alu_b_d    = i_use_imm ? i_imm : rf_read(rf_q, i_rt);
                    alu_bneg_d = in_instr[12];
                    alu_op_d   = in_instr[15:13];
                    rd_d       = i_rd;
                end
            end
            S_EXEC: begin
                state_d   = S_WB;
                wb_data_d = alu_result;
                pend_d    = {alu_zero, alu_ovf, alu_cout};
            end
            S_WB: begin
                if (wb_ready) begin
                    state_d = S_IDLE;
                    flags_d = pend_q;
                    if (rd_q != 3'd0) rf_d[rd_q] = wb_data_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_bneg_q <= 1'b0;
            alu_op_q   <= '0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            pend_q     <= '0;
            flags_q    <= '0;
            rf_q       <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_bneg_q <= alu_bneg_d;
            alu_op_q   <= alu_op_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
            pend_q     <= pend_d;
            flags_q    <= flags_d;
            rf_q       <= rf_d;
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign wb_valid = (state_q == S_WB);
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_bneg = alu_bneg_q;
    assign alu_op   = alu_op_q;
    assign wb_rd    = rd_q;
    assign wb_data  = wb_data_q;
    assign flag_z   = flags_q[2];
    assign flag_v   = flags_q[1];
    assign flag_c   = flags_q[0];
    assign dbg_data = rf_read(rf_q, dbg_addr);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: behavioural ALU16 on the ALU port, register-file and
// flag reference model, directed scenarios followed by randomized instructions.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic [15:0] alu_a, alu_b;
    logic        alu_bneg;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_zero, alu_ovf, alu_cout;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        flag_z, flag_v, flag_c;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int checks = 0;
    int failures = 0;

    // reference state
    logic [15:0] rm [8];
    logic        mz, mv, mc;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_bneg(alu_bneg),
        .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_ovf(alu_ovf), .alu_cout(alu_cout), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .flag_z(flag_z),
        .flag_v(flag_v), .flag_c(flag_c), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // behavioural ALU16: returns {zero, ovf, cout, result}
    function automatic logic [18:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic bneg, input logic [2:0] op);
        logic [15:0] be, r;
        logic [16:0] s;
        logic v, c;
        be = bneg ? ~b : b;
        s  = {1'b0, a} + {1'b0, be} + {16'h0, bneg};
        v  = 1'b0;
        c  = 1'b0;
        case (op)
            3'b000: r = a & be;
            3'b001: r = a | be;
            3'b010: begin
                r = s[15:0];
                c = s[16];
                v = (a[15] == be[15]) && (r[15] != a[15]);
            end
            default: r = 16'h0000;
        endcase
        return {(r == 16'h0000), v, c, r};
    endfunction

    assign {alu_zero, alu_ovf, alu_cout, alu_result} = alu_fn(alu_a, alu_b, alu_bneg, alu_op);

    function automatic logic [15:0] enc(input logic [2:0] op, input logic bn, input logic ui,
                                        input logic [2:0] rd, input logic [2:0] rs,
                                        input logic [4:0] lo);
        return {op, bn, ui, rd, rs, lo};
    endfunction

    function automatic logic [15:0] sext5(input logic [4:0] i);
        return {{11{i[4]}}, i};
    endfunction

    function automatic logic [18:0] model_exec(input logic [15:0] ins);
        logic [15:0] a, b;
        a = rm[ins[7:5]];
        b = ins[11] ? sext5(ins[4:0]) : rm[ins[4:2]];
        return alu_fn(a, b, ins[12], ins[15:13]);
    endfunction

    task automatic model_commit(input logic [15:0] ins, input logic [18:0] o);
        if (ins[10:8] != 3'd0) rm[ins[10:8]] = o[15:0];
        {mz, mv, mc} = o[18:16];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) rm[i] = 16'h0000;
        {mz, mv, mc} = 3'b000;
    endtask

    task automatic peek(input logic [2:0] a, output logic [15:0] v);
        dbg_addr = a;
        #1 v = dbg_data;
    endtask

    task automatic send(input logic [15:0] ins);
        @(negedge clk);
        in_instr = ins;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = 16'($urandom);
    endtask

    // issue with wb_ready high; lat = edges from accept to writeback handshake (-1 on timeout)
    task automatic exec_wb(input logic [15:0] ins, output logic [15:0] d,
                           output logic [2:0] rd, output int lat);
        wb_ready = 1'b1;
        lat = -1;
        d = 'x;
        rd = 'x;
        send(ins);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (wb_valid) begin
                d  = wb_data;
                rd = wb_rd;
                @(posedge clk);
                lat = k;
                break;
            end
            @(posedge clk);
        end
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] v, d;
        logic [2:0] rd;
        int lat;
        model_reset();
        #3;
        checks++; if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin failures++;
            $display("FAIL reset_hs: in_ready=%b wb_valid=%b want 1 0", in_ready, wb_valid); end
        checks++; if ({alu_a, alu_b, alu_bneg, alu_op, wb_rd, wb_data} !== '0) begin failures++;
            $display("FAIL reset_outs: a=%h b=%h bn=%b op=%h rd=%h d=%h want 0", alu_a, alu_b, alu_bneg, alu_op, wb_rd, wb_data); end
        checks++; if ({flag_z, flag_v, flag_c} !== 3'b000) begin failures++;
            $display("FAIL reset_flags: zvc=%b%b%b want 000", flag_z, flag_v, flag_c); end
        for (int i = 0; i < 8; i++) begin
            peek(3'(i), v);
            checks++; if (v !== 16'h0000) begin failures++;
                $display("FAIL reset_dbg r%0d: got %h want 0000", i, v); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        // load something, then reset asynchronously away from the clock edge
        exec_wb(enc(3'b010, 1'b0, 1'b1, 3'd1, 3'd0, 5'd7), d, rd, lat);
        peek(3'd1, v);
        checks++; if (v !== 16'h0007) begin failures++;
            $display("FAIL pre_async_r1: got %h want 0007", v); end
        @(posedge clk);
        #3 rst_n = 1'b0;
        peek(3'd1, v);
        checks++; if (v !== 16'h0000 || alu_b !== 16'h0000 || wb_data !== 16'h0000) begin failures++;
            $display("FAIL async_reset: r1=%h alu_b=%h wb_data=%h want 0", v, alu_b, wb_data); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_imm_add();
        logic [15:0] ins [3];
        logic [15:0] want [3];
        logic [15:0] d, v;
        logic [2:0] rd;
        logic [18:0] o;
        int lat;
        ins[0] = enc(3'b010, 1'b0, 1'b1, 3'd1, 3'd0, 5'b00101);
        ins[1] = enc(3'b010, 1'b0, 1'b1, 3'd2, 3'd0, 5'b11111);
        ins[2] = enc(3'b010, 1'b0, 1'b0, 3'd3, 3'd1, {3'd2, 2'b00});
        want[0] = 16'h0005; want[1] = 16'hFFFF; want[2] = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            o = model_exec(ins[i]);
            exec_wb(ins[i], d, rd, lat);
            model_commit(ins[i], o);
            checks++; if (lat !== 2) begin failures++;
                $display("FAIL imm_add_latency %0d: got %0d want 2", i, lat); end
            checks++; if (d !== want[i] || d !== o[15:0]) begin failures++;
                $display("FAIL imm_add_data %0d: got %h want %h", i, d, want[i]); end
            peek(ins[i][10:8], v);
            checks++; if (v !== want[i]) begin failures++;
                $display("FAIL imm_add_reg %0d: got %h want %h", i, v, want[i]); end
        end
        checks++; if ({flag_z, flag_v, flag_c} !== 3'b001) begin failures++;
            $display("FAIL imm_add_flags: zvc=%b%b%b want 001", flag_z, flag_v, flag_c); end
    endtask

    task automatic test_sub_compare();
        logic [15:0] ins, d, v;
        logic [2:0] rd;
        logic [18:0] o;
        int lat;
        ins = enc(3'b010, 1'b1, 1'b0, 3'd0, 3'd1, {3'd1, 2'b00});
        o = model_exec(ins);
        exec_wb(ins, d, rd, lat);
        model_commit(ins, o);
        checks++; if (lat !== 2 || d !== 16'h0000 || rd !== 3'd0) begin failures++;
            $display("FAIL sub_wb: lat=%0d data=%h rd=%0d want 2 0000 0", lat, d, rd); end
        checks++; if ({flag_z, flag_v, flag_c} !== 3'b101) begin failures++;
            $display("FAIL sub_flags: zvc=%b%b%b want 101", flag_z, flag_v, flag_c); end
        peek(3'd0, v);
        checks++; if (v !== 16'h0000) begin failures++;
            $display("FAIL sub_r0: got %h want 0000", v); end
    endtask

    task automatic test_overflow();
        logic [15:0] ins, d, v;
        logic [2:0] rd;
        logic [18:0] o;
        int lat;
        // R4 = 2*R4 | 1 repeated, building 0x7FFF
        ins = enc(3'b010, 1'b0, 1'b1, 3'd4, 3'd0, 5'd1);
        o = model_exec(ins); exec_wb(ins, d, rd, lat); model_commit(ins, o);
        for (int i = 0; i < 14; i++) begin
            ins = enc(3'b010, 1'b0, 1'b0, 3'd4, 3'd4, {3'd4, 2'b00});
            o = model_exec(ins); exec_wb(ins, d, rd, lat); model_commit(ins, o);
            ins = enc(3'b001, 1'b0, 1'b1, 3'd4, 3'd4, 5'd1);
            o = model_exec(ins); exec_wb(ins, d, rd, lat); model_commit(ins, o);
        end
        peek(3'd4, v);
        checks++; if (v !== 16'h7FFF) begin failures++;
            $display("FAIL ovf_r4: got %h want 7fff", v); end
        ins = enc(3'b010, 1'b0, 1'b1, 3'd5, 3'd4, 5'd1);
        o = model_exec(ins); exec_wb(ins, d, rd, lat); model_commit(ins, o);
        peek(3'd5, v);
        checks++; if (v !== 16'h8000) begin failures++;
            $display("FAIL ovf_r5: got %h want 8000", v); end
        checks++; if ({flag_z, flag_v, flag_c} !== 3'b010) begin failures++;
            $display("FAIL ovf_flags: zvc=%b%b%b want 010", flag_z, flag_v, flag_c); end
    endtask

    task automatic test_backpressure();
        logic [15:0] ins, v, old_r7;
        logic [18:0] o;
        ins = enc(3'b010, 1'b0, 1'b0, 3'd7, 3'd1, {3'd3, 2'b00});
        o = model_exec(ins);
        old_r7 = rm[7];
        wb_ready = 1'b0;
        send(ins);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = 16'($urandom);
            checks++; if (wb_valid !== 1'b1 || in_ready !== 1'b0) begin failures++;
                $display("FAIL stall_hs %0d: wb_valid=%b in_ready=%b want 1 0", i, wb_valid, in_ready); end
            checks++; if (wb_data !== o[15:0] || wb_rd !== 3'd7) begin failures++;
                $display("FAIL stall_data %0d: data=%h rd=%0d want %h 7", i, wb_data, wb_rd, o[15:0]); end
            peek(3'd7, v);
            checks++; if (v !== old_r7 || {flag_z, flag_v, flag_c} !== {mz, mv, mc}) begin failures++;
                $display("FAIL stall_state %0d: r7=%h zvc=%b%b%b want %h %b%b%b", i, v, flag_z, flag_v, flag_c, old_r7, mz, mv, mc); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        wb_ready = 1'b1;
        @(posedge clk);
        model_commit(ins, o);
        #1;
        peek(3'd7, v);
        checks++; if (v !== rm[7] || {flag_z, flag_v, flag_c} !== {mz, mv, mc}) begin failures++;
            $display("FAIL stall_release: r7=%h zvc=%b%b%b want %h %b%b%b", v, flag_z, flag_v, flag_c, rm[7], mz, mv, mc); end
        checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
            $display("FAIL stall_done: wb_valid=%b in_ready=%b want 0 1", wb_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] ins, v;
        logic [18:0] o;
        wb_ready = 1'b1;
        send(enc(3'b010, 1'b0, 1'b1, 3'd6, 3'd1, 5'd3));
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b1 || alu_a !== 16'h0000) begin failures++;
            $display("FAIL mid_reset_outs: wb_valid=%b in_ready=%b alu_a=%h want 0 1 0000", wb_valid, in_ready, alu_a); end
        @(negedge clk);
        ins = enc(3'b010, 1'b0, 1'b1, 3'd2, 3'd0, 5'd9);
        o = model_exec(ins);
        rst_n = 1'b1;
        in_instr = ins;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || alu_b !== 16'h0009) begin failures++;
            $display("FAIL mid_reset_accept: in_ready=%b alu_b=%h want 0 0009", in_ready, alu_b); end
        @(posedge clk);
        @(posedge clk);
        #1;
        model_commit(ins, o);
        peek(3'd6, v);
        checks++; if (v !== 16'h0000) begin failures++;
            $display("FAIL mid_reset_r6: got %h want 0000", v); end
        peek(3'd2, v);
        checks++; if (v !== rm[2] || {flag_z, flag_v, flag_c} !== {mz, mv, mc}) begin failures++;
            $display("FAIL mid_reset_next: r2=%h zvc=%b%b%b want %h %b%b%b", v, flag_z, flag_v, flag_c, rm[2], mz, mv, mc); end
    endtask

    task automatic test_random();
        logic [15:0] ins, d, v;
        logic [2:0] rd;
        logic [18:0] o;
        int lat;
        for (int i = 0; i < 30; i++) begin
            ins = enc(3'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                      3'($urandom), 3'($urandom), 5'($urandom));
            o = model_exec(ins);
            exec_wb(ins, d, rd, lat);
            model_commit(ins, o);
            checks++; if (lat !== 2 || d !== o[15:0] || rd !== ins[10:8]) begin failures++;
                $display("FAIL rand_wb %0d: lat=%0d data=%h rd=%0d want 2 %h %0d", i, lat, d, rd, o[15:0], ins[10:8]); end
            peek(ins[10:8], v);
            checks++; if (v !== rm[ins[10:8]] || {flag_z, flag_v, flag_c} !== {mz, mv, mc}) begin failures++;
                $display("FAIL rand_state %0d: reg=%h zvc=%b%b%b want %h %b%b%b", i, v, flag_z, flag_v, flag_c, rm[ins[10:8]], mz, mv, mc); end
        end
    endtask

    initial begin
        test_reset();
        test_imm_add();
        test_sub_compare();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
